mem_lsu: RTL

Parametrised load/store unit for the MEM stage. It replaces the fixed-latency simulation memory hookup with a req/ack/rvalid handshake to an external data memory of any latency. It adds byte, halfword, word and (for 64-bit) doubleword access with sign/zero extension, misalignment detection, a pipeline stall and a timeout watchdog. It also resolves all conditional-branch types into o_PCSrc.

---
 rtl/mem_lsu.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_lsu.sv
// mem_lsu -- MEM-stage load/store unit.
//
// Drives a req/ack/rvalid data-memory port of arbitrary latency.
// - Supports byte, half, word and (when DATA_W=64) dword accesses.
// - Loads are sign- or zero-extended.
// - Misaligned accesses are flagged in the same cycle and never issued.
// - Upstream stages are stalled while a transaction is in flight.
// - A watchdog aborts transactions that never complete.
// - Conditional branches and jumps are also resolved here, into o_PCSrc.
//
// Handshake: a request is presented on o_mem_req/o_mem_* for as long as the
// FSM sits in REQ and is consumed on the cycle i_mem_ack is high. Read data
// is consumed on the first cycle i_mem_rvalid is high, either together with
// the ack or on any later cycle while in RESP. Outside REQ and RESP, both
// i_mem_ack and i_mem_rvalid are ignored.
//
// Ports:
//   i_clk, i_reset_n        clock, asynchronous active-low reset
//   i_valid                 instruction present in MEM
//   i_memRead, i_memWrite   load / store
//   i_size, i_unsigned      access size (00 b, 01 h, 10 w, 11 d) and zero-extend
//   i_memAddr, i_wrData     byte address, LSB-justified store data
//   i_branch, i_jump        conditional branch / unconditional jump
//   i_funct3                branch condition select
//   i_zero, i_lt, i_ltu     ALU flags
//   o_readData              extended load result, held until the next load
//   o_stall                 freeze upstream stages
//   o_misaligned            access fault, combinational
//   o_timeout               one-cycle watchdog abort pulse
//   o_PCSrc                 take branch/jump
//   o_mem_*                 memory request side
//   i_mem_*                 memory response side
//   o_dbg_state             current FSM state (IDLE=0, REQ=1, RESP=2, DONE=3)
module mem_lsu #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_valid,
    input  logic                i_memRead,
    input  logic                i_memWrite,
    input  logic [1:0]          i_size,
    input  logic                i_unsigned,
    input  logic [ADDR_W-1:0]   i_memAddr,
    input  logic [DATA_W-1:0]   i_wrData,
    input  logic                i_branch,
    input  logic                i_jump,
    input  logic [2:0]          i_funct3,
    input  logic                i_zero,
    input  logic                i_lt,
    input  logic                i_ltu,
    output logic [DATA_W-1:0]   o_readData,
    output logic                o_stall,
    output logic                o_misaligned,
    output logic                o_timeout,
    output logic                o_PCSrc,
    output logic                o_mem_req,
    output logic                o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W/8-1:0] o_mem_be,
    output logic [DATA_W-1:0]   o_mem_wdata,
    input  logic                i_mem_ack,
    input  logic                i_mem_rvalid,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    output logic [1:0]          o_dbg_state
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              r_state, w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [1:0]          r_size;
    logic                r_unsigned;
    logic                r_we;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_readData;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_timeout;

    logic                w_bad_align, w_access, w_accept;
    logic                w_expire, w_capture, w_abort;
    logic [OFF_W-1:0]    w_lane;
    logic [DATA_W-1:0]   w_shift, w_mask, w_load_ext, w_wdata_rep;
    logic                w_sign;
    logic [NB-1:0]       w_be_base;
    logic                w_cond;

    // Alignment check. A dword access on a 32-bit path is always a fault.
    always_comb begin
        w_bad_align = 1'b0;
        case (i_size)
            2'b00:   w_bad_align = 1'b0;
            2'b01:   w_bad_align = i_memAddr[0];
            2'b10:   w_bad_align = |i_memAddr[1:0];
            default: w_bad_align = (DATA_W == 32) ? 1'b1 : |i_memAddr[2:0];
        endcase
    end

    assign w_access     = i_valid & (i_memRead | i_memWrite);
    assign o_misaligned = w_access & w_bad_align;
    assign w_accept     = (r_state == IDLE) & w_access & ~w_bad_align;

    // Bring the addressed lane down to bit 0, then extend it.
    assign w_lane  = r_addr[OFF_W-1:0];
    assign w_shift = i_mem_rdata >> {w_lane, 3'b000};

    always_comb begin
        w_mask = '1;
        w_sign = 1'b0;
        case (r_size)
            2'b00: begin
                w_mask = DATA_W'(64'h0000_0000_0000_00FF);
                w_sign = w_shift[7];
            end
            2'b01: begin
                w_mask = DATA_W'(64'h0000_0000_0000_FFFF);
                w_sign = w_shift[15];
            end
            2'b10: begin
                w_mask = DATA_W'(64'h0000_0000_FFFF_FFFF);
                w_sign = w_shift[31];
            end
            default: begin
                w_mask = '1;
                w_sign = 1'b0;
            end
        endcase
        w_load_ext = (w_shift & w_mask) | ((w_sign & ~r_unsigned) ? ~w_mask : '0);
    end

    // Byte enables and lane-replicated store data.
    always_comb begin
        w_be_base   = '0;
        w_wdata_rep = r_wdata;
        case (r_size)
            2'b00: begin
                w_be_base   = NB'(8'h01);
                w_wdata_rep = {NB{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be_base   = NB'(8'h03);
                w_wdata_rep = {(NB/2){r_wdata[15:0]}};
            end
            2'b10: begin
                w_be_base   = NB'(8'h0F);
                w_wdata_rep = {(NB/4){r_wdata[31:0]}};
            end
            default: begin
                w_be_base   = NB'(8'hFF);
                w_wdata_rep = r_wdata;
            end
        endcase
    end

    // The watchdog fires on the last permitted REQ/RESP cycle. A completion
    // arriving on that same cycle takes priority over the abort.
    assign w_expire = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_abort   = 1'b0;
        case (r_state)
            IDLE: if (w_accept) w_next = REQ;
            REQ: begin
                if (i_mem_ack) begin
                    if (r_we) begin
                        w_next = DONE;
                    end else if (i_mem_rvalid) begin
                        w_next    = DONE;
                        w_capture = 1'b1;
                    end else begin
                        w_next = RESP;
                    end
                end else if (w_expire) begin
                    w_next  = DONE;
                    w_abort = 1'b1;
                end
            end
            RESP: begin
                if (i_mem_rvalid) begin
                    w_next    = DONE;
                    w_capture = 1'b1;
                end else if (w_expire) begin
                    w_next  = DONE;
                    w_abort = 1'b1;
                end
            end
            // DONE drops the stall for one cycle so the instruction retires
            // before IDLE can look at i_valid again.
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_size     <= '0;
            r_unsigned <= 1'b0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_readData <= '0;
            r_cnt      <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_timeout <= w_abort;
            if (w_accept) begin
                r_addr     <= i_memAddr;
                r_size     <= i_size;
                r_unsigned <= i_unsigned;
                r_we       <= i_memWrite;
                r_wdata    <= i_wrData;
            end
            if (w_capture) begin
                r_readData <= w_load_ext;
            end else if (w_abort && !r_we) begin
                r_readData <= '0;
            end
            if (r_state == IDLE) begin
                r_cnt <= '0;
            end else if (r_state == REQ || r_state == RESP) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_stall     = w_accept | (r_state == REQ) | (r_state == RESP);
    assign o_mem_req   = (r_state == REQ);
    assign o_mem_we    = (r_state == REQ) & r_we;
    assign o_mem_addr  = (r_state == REQ) ? {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign o_mem_be    = (r_state == REQ) ? (w_be_base << w_lane) : '0;
    assign o_mem_wdata = (r_state == REQ) ? w_wdata_rep : '0;
    assign o_readData  = r_readData;
    assign o_timeout   = r_timeout;
    assign o_dbg_state = r_state;

    // Branch resolution.
    always_comb begin
        w_cond = 1'b0;
        case (i_funct3)
            3'b000:  w_cond = i_zero;
            3'b001:  w_cond = ~i_zero;
            3'b100:  w_cond = i_lt;
            3'b101:  w_cond = ~i_lt;
            3'b110:  w_cond = i_ltu;
            3'b111:  w_cond = ~i_ltu;
            default: w_cond = 1'b0;
        endcase
    end

    assign o_PCSrc = i_jump | (i_branch & w_cond);

endmodule
